// File: rtl/sample_reader.sv
// sample_reader: clock-divided DUT output sampler feeding a first-word
// fall-through FIFO that a checker drains over a valid/ready handshake.
// Optional feature macro SAMPLE_READER_INDEX_EN adds a 32-bit strobe
// counter stored with every entry and presented on rd_index.
module sample_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 4,
   parameter int DEPTH      = 16
) (
   input  logic                     reading_clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [DATA_WIDTH-1:0]    dut_data,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [15:0]              drop_cnt
`ifdef SAMPLE_READER_INDEX_EN
   ,
   output logic [31:0]              rd_index
`endif
);

   localparam int AW  = $clog2(DEPTH);
   localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DVW-1:0]        r_div;
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_level;
   logic                  r_overflow;
   logic [15:0]           r_drop;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_strobe;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_full   = (r_level == (AW+1)'(DEPTH));
   assign w_empty  = (r_level == '0);
   assign w_strobe = enable & (r_div == DVW'(CLK_DIV-1));
   assign w_pop    = ~w_empty & rd_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign w_push   = w_strobe & (~w_full | w_pop);
   assign w_drop   = w_strobe & w_full & ~w_pop;

   // Sample divider: counts enabled cycles, held at zero while disabled.
   always_ff @(posedge reading_clk or negedge reset_n) begin
      if (!reset_n)                       r_div <= '0;
      else if (clear || !enable)          r_div <= '0;
      else if (r_div == DVW'(CLK_DIV-1))  r_div <= '0;
      else                                r_div <= r_div + 1'b1;
   end

   // FIFO pointers and occupancy; clear wins over any push/pop.
   always_ff @(posedge reading_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge reading_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
         r_drop     <= '0;
      end else if (clear) begin
         r_overflow <= 1'b0;
         r_drop     <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
      end
   end

   // Sample storage; contents need no reset since the output is gated.
   always_ff @(posedge reading_clk) begin
      if (!clear && w_push) r_mem[r_wr_ptr] <= dut_data;
   end

   assign rd_valid = ~w_empty;
   assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign level    = r_level;
   assign overflow = r_overflow;
   assign drop_cnt = r_drop;

`ifdef SAMPLE_READER_INDEX_EN
   logic [31:0] r_sidx;
   logic [31:0] r_imem [DEPTH];

   // Strobe counter: counts every strobe, dropped ones included, so gaps show.
   always_ff @(posedge reading_clk or negedge reset_n) begin
      if (!reset_n)      r_sidx <= '0;
      else if (clear)    r_sidx <= '0;
      else if (w_strobe) r_sidx <= r_sidx + 1'b1;
   end

   // Index storage written alongside the sample data.
   always_ff @(posedge reading_clk) begin
      if (!clear && w_push) r_imem[r_wr_ptr] <= r_sidx;
   end

   assign rd_index = w_empty ? '0 : r_imem[r_rd_ptr];
`endif

endmodule

// File: tb/tb_sample_reader.sv
// tb_sample_reader: randomized bench for sample_reader with a queue-based
// reference model. Define SAMPLE_READER_INDEX_EN to also cover rd_index.
module tb_sample_reader;

   localparam int DW = 16;
   localparam int CD = 4;
   localparam int DP = 16;
   localparam int LW = $clog2(DP) + 1;

   logic          reading_clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] dut_data = '0;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [LW-1:0] level;
   logic          overflow;
   logic [15:0]   drop_cnt;
`ifdef SAMPLE_READER_INDEX_EN
   logic [31:0]   rd_index;
`endif

   sample_reader #(.DATA_WIDTH(DW), .CLK_DIV(CD), .DEPTH(DP)) dut (
      .reading_clk(reading_clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .clear      (clear),
      .dut_data   (dut_data),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .level      (level),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt)
`ifdef SAMPLE_READER_INDEX_EN
      ,
      .rd_index   (rd_index)
`endif
   );

   always #5 reading_clk = ~reading_clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: FIFO contents as queues, strobes from enabled-edge count
   logic [DW-1:0] mq[$];
   int unsigned   mi[$];
   int            m_run  = 0;
   bit            m_ovf  = 0;
   int            m_drop = 0;
   int unsigned   m_sidx = 0;

   task automatic model_reset();
      mq.delete(); mi.delete();
      m_run = 0; m_ovf = 0; m_drop = 0; m_sidx = 0;
   endtask

   // one clock edge; the model consumes the inputs present at that edge
   task automatic step();
      bit stb, pp;
      @(posedge reading_clk);
      if (clear) model_reset();
      else begin
         pp  = rd_ready && (mq.size() > 0);
         stb = 0;
         if (!enable) m_run = 0;
         else begin
            m_run++;
            stb = ((m_run % CD) == 0);
         end
         if (pp) begin void'(mq.pop_front()); void'(mi.pop_front()); end
         if (stb) begin
            if (mq.size() < DP) begin mq.push_back(dut_data); mi.push_back(m_sidx); end
            else begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
            m_sidx++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge reading_clk);
      #1;
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rd_valid); else n_pass++;
      n_chk++; if (level !== '0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
      n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
      n_chk++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else n_pass++;
      n_chk++; if (rd_data !== '0) $display("FAIL reset_data got %h want 0", rd_data); else n_pass++;
`ifdef SAMPLE_READER_INDEX_EN
      n_chk++; if (rd_index !== 32'd0) $display("FAIL reset_index got %0d want 0", rd_index); else n_pass++;
`endif
      reset_n = 1'b1;
   endtask

   task automatic test_first_strobe();
      enable = 1'b1; rd_ready = 1'b0; dut_data = 16'h00A5;
      for (int k = 1; k <= CD; k++) begin
         step();
         n_chk++;
         if (rd_valid !== (k == CD)) $display("FAIL first_valid edge %0d got %b want %b", k, rd_valid, (k == CD));
         else n_pass++;
      end
      n_chk++; if (rd_data !== 16'h00A5) $display("FAIL first_data got %h want 00a5", rd_data); else n_pass++;
   endtask

   task automatic test_streaming();
      logic [DW-1:0] base, last;
      bit have_last;
      int bad;
      base = DW'($urandom); have_last = 0; bad = 0;
      clear = 1'b1; step(); clear = 1'b0;
      rd_ready = 1'b1;
      for (int k = 0; k < 40 * CD; k++) begin
         dut_data = base + DW'(k);
         if (rd_valid && rd_ready) begin
            if (have_last && rd_data !== last + DW'(CD)) bad++;
            last = rd_data; have_last = 1;
         end
         step();
         if (level > 1 || overflow !== 1'b0 || level !== LW'(mq.size())) bad++;
         if (mq.size() > 0 && rd_data !== mq[0]) bad++;
      end
      n_chk++; if (bad != 0) $display("FAIL streaming got %0d bad cycles want 0", bad); else n_pass++;
      n_chk++; if (!have_last) $display("FAIL streaming_rx got 0 samples want >0"); else n_pass++;
   endtask

   task automatic test_overflow();
      logic [DW-1:0] exp[$];
      int bad;
      bad = 0;
      clear = 1'b1; step(); clear = 1'b0;
      rd_ready = 1'b0; enable = 1'b1;
      for (int k = 0; k < 20 * CD; k++) begin
         dut_data = DW'($urandom);
         if ((m_run + 1) % CD == 0 && exp.size() < DP) exp.push_back(dut_data);
         step();
         if (level !== LW'(mq.size()) || drop_cnt !== 16'(m_drop) || overflow !== m_ovf) bad++;
      end
      n_chk++; if (bad != 0) $display("FAIL ovf_track got %0d bad cycles want 0", bad); else n_pass++;
      n_chk++; if (level !== LW'(DP)) $display("FAIL ovf_level got %0d want %0d", level, DP); else n_pass++;
      n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
      n_chk++; if (drop_cnt !== 16'd4) $display("FAIL ovf_drop got %0d want 4", drop_cnt); else n_pass++;
      enable = 1'b0; rd_ready = 1'b1;
      bad = 0;
      for (int k = 0; k < DP; k++) begin
         if (rd_valid !== 1'b1 || rd_data !== exp[k]) bad++;
         step();
      end
      rd_ready = 1'b0;
      n_chk++; if (bad != 0) $display("FAIL ovf_drain got %0d bad words want 0", bad); else n_pass++;
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", rd_valid); else n_pass++;
   endtask

   task automatic test_clear_enable();
      int cnt;
      enable = 1'b1; rd_ready = 1'b0; cnt = 0;
      while (mq.size() < 5 && cnt < 100) begin dut_data = DW'($urandom); step(); cnt++; end
      while ((m_run + 1) % CD != 0 && cnt < 100) begin step(); cnt++; end
      n_chk++; if (level !== LW'(5)) $display("FAIL clr_pre_level got %0d want 5", level); else n_pass++;
      clear = 1'b1; step(); clear = 1'b0;
      n_chk++; if (level !== '0) $display("FAIL clr_level got %0d want 0", level); else n_pass++;
      n_chk++; if (overflow !== 1'b0) $display("FAIL clr_ovf got %b want 0", overflow); else n_pass++;
      n_chk++; if (drop_cnt !== 16'd0) $display("FAIL clr_drop got %0d want 0", drop_cnt); else n_pass++;
      step();
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL clr_nopush got %b want 0", rd_valid); else n_pass++;
      // divider now at 1; one more edge reaches 2, then pause and resume
      step();
      enable = 1'b0; step(); enable = 1'b1;
      for (int k = 1; k <= CD; k++) begin
         step();
         n_chk++;
         if (rd_valid !== (k == CD) || rd_valid !== (mq.size() > 0))
            $display("FAIL reenable edge %0d got %b want %b", k, rd_valid, (k == CD));
         else n_pass++;
      end
   endtask

   task automatic test_full_pushpop();
      int cnt, d0;
      logic [DW-1:0] second;
      clear = 1'b1; step(); clear = 1'b0;
      enable = 1'b1; rd_ready = 1'b0; cnt = 0;
      while (mq.size() < DP && cnt < 500) begin dut_data = DW'($urandom); step(); cnt++; end
      while ((m_run + 1) % CD != 0 && cnt < 500) begin step(); cnt++; end
      d0 = m_drop; second = mq[1];
      dut_data = DW'($urandom);
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      n_chk++; if (level !== LW'(DP)) $display("FAIL pp_level got %0d want %0d", level, DP); else n_pass++;
      n_chk++; if (drop_cnt !== 16'(d0)) $display("FAIL pp_drop got %0d want %0d", drop_cnt, d0); else n_pass++;
      n_chk++; if (rd_data !== second) $display("FAIL pp_head got %h want %h", rd_data, second); else n_pass++;
   endtask

`ifdef SAMPLE_READER_INDEX_EN
   task automatic test_index();
      int cnt, bad;
      clear = 1'b1; step(); clear = 1'b0;
      enable = 1'b1; rd_ready = 1'b0; cnt = 0;
      while (m_sidx < DP + 2 && cnt < 500) begin dut_data = DW'($urandom); step(); cnt++; end
      enable = 1'b0; rd_ready = 1'b1; bad = 0;
      for (int k = 0; k < DP; k++) begin
         if (rd_valid !== 1'b1 || rd_index !== 32'(k)) bad++;
         step();
      end
      rd_ready = 1'b0;
      n_chk++; if (bad != 0) $display("FAIL idx_drain got %0d bad want 0", bad); else n_pass++;
      enable = 1'b1;
      for (int k = 0; k < CD; k++) step();
      n_chk++; if (rd_index !== 32'(DP + 2)) $display("FAIL idx_next got %0d want %0d", rd_index, DP + 2); else n_pass++;
   endtask
`endif

   task automatic test_async_reset();
      enable = 1'b1; rd_ready = 1'b0;
      for (int k = 0; k < 3 * CD; k++) begin dut_data = DW'($urandom); step(); end
      n_chk++; if (level !== LW'(mq.size())) $display("FAIL ar_pre got %0d want %0d", level, mq.size()); else n_pass++;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      n_chk++; if (rd_valid !== 1'b0 || level !== '0) $display("FAIL async_reset got valid %b level %0d want 0 0", rd_valid, level); else n_pass++;
      #1 reset_n = 1'b1;
      enable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_strobe();
      test_streaming();
      test_overflow();
      test_clear_enable();
      test_full_pushpop();
`ifdef SAMPLE_READER_INDEX_EN
      test_index();
`endif
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sample_reader.md
# sample_reader

Testbench-side capture block that reads DUT output samples at a fixed sample rate and buffers them for the checker. It is the reading-end counterpart of the stimulus writer: a clock-divided sample strobe latches `dut_data` into a FIFO, and the checker drains it through a valid/ready handshake. Sits between the DUT outputs and the scoreboard, entirely in the `reading_clk` domain.

## Interface
- `DATA_WIDTH`, 16, width of one DUT output sample
- `CLK_DIV`, 4, `reading_clk` cycles per sample strobe (legal range ≥1)
- `DEPTH`, 16, FIFO entries, power of two (legal range ≥2)
- `reading_clk`  in  1  sole clock, all logic on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  sampling enable; low holds the divider at 0
- `clear`  in  1  synchronous flush of FIFO, overflow flag and counters
- `dut_data`  in  DATA_WIDTH  DUT output word to sample
- `rd_data`  out  DATA_WIDTH  head-of-FIFO sample
- `rd_valid`  out  1  FIFO not empty
- `rd_ready`  in  1  checker accepts `rd_data` when `rd_valid & rd_ready`
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `overflow`  out  1  sticky: a strobe occurred while the FIFO was full
- `drop_cnt`  out  16  strobes lost to overflow, saturating at 16'hFFFF
- `rd_index`  out  32  sample index of head entry (only with `SAMPLE_READER_INDEX_EN`)

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 while `enable`=1 and wraps to 0. `enable`=0 forces it to 0. With CLK_DIV=1 the strobe fires every enabled cycle.
- Strobe = `enable & (div_cnt == CLK_DIV-1)`. On a strobe edge, `dut_data` sampled at that edge is pushed.
- Pop = `rd_valid & rd_ready`.
- Full, with strobe and no pop: the sample is dropped, `overflow`←1, and `drop_cnt` increments (saturating).
- Full, with strobe and pop on the same edge: both are performed and nothing is dropped. `level` stays at DEPTH.
- Empty, with strobe: push only. Pop is impossible because `rd_valid`=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `level`.
- `rd_valid`/`rd_data` are first-word fall-through. The head entry is visible whenever `level`>0.
- `clear`=1 has priority over everything on that edge: `level`←0, pointers←0, `overflow`←0, `drop_cnt`←0, divider←0, sample index←0. A strobe coinciding with `clear` is discarded.
- `rd_data` is don't-care when `rd_valid`=0. The bench must not check it.

## Timing
- Reset values: `rd_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0, `rd_data`=0, `rd_index`=0. The divider and pointers are also reset to 0.
- Reset asserted mid-operation clears all state immediately and asynchronously; buffered samples are lost. Release is synchronous to the next `reading_clk` edge.
- First strobe occurs CLK_DIV edges after `enable` rises, i.e. on the edge where `div_cnt` reaches CLK_DIV-1.
- Push latency: a sample taken at edge N gives `rd_valid`=1 and `rd_data` equal to that sample after edge N, when the FIFO was empty.
- Pop: on the edge where `rd_valid & rd_ready`, the head advances. The next entry, or `rd_valid`=0, is visible after that edge.
- `level`, `overflow` and `drop_cnt` update on the same edge as the push/pop/drop that causes them.
- Throughput: one sample per CLK_DIV cycles in and one sample per cycle out.

## Configuration
- `SAMPLE_READER_INDEX_EN` defined:
  - A 32-bit sample counter increments on every strobe, including dropped ones, and wraps at 2^32.
  - Each pushed entry stores the counter value alongside the data.
  - `rd_index` presents the head entry's index with the same timing as `rd_data`, letting the checker detect gaps.
  - `clear` resets the counter.
- Not defined: no counter and no index storage; the `rd_index` port is absent.

## Test plan
- Reset state: hold `reset_n`=0 → all outputs at their reset values. Release, `enable`=1, CLK_DIV=4, `dut_data`=16'h00A5 → `rd_valid` rises after the 4th edge and `rd_data`=16'h00A5.
- Streaming: `dut_data` increments by 1 every cycle, `rd_ready`=1 → received samples step by 4 (3, 7, 11, …). `level` never exceeds 1. `overflow` stays 0.
- Overflow: `rd_ready`=0 for 20 strobes with DEPTH=16 → `level`=16, `overflow`=1, `drop_cnt`=4. Then drain 16 → the first 16 samples arrive in order and `rd_valid`=0.
- Full with simultaneous push/pop: at `level`=16, assert `rd_ready` for exactly the strobe cycle → `level` stays 16 and `drop_cnt` is unchanged.
- Clear and enable: pulse `clear` at `level`=5 coincident with a strobe → `level`=0, `overflow`=0, `drop_cnt`=0, and no push occurs. Drop `enable` at `div_cnt`=2, re-enable → the next strobe comes 4 edges later.
- Index (with `SAMPLE_READER_INDEX_EN`): overflow by 2, then drain → indices 0..15, and the next accepted sample after the drain has index 18.
